// File: rtl/pwmcapture8_pkg.sv
// pwmcapture8 shared types and constants.
// FSM encodings and the 8-bit saturating counter helper.
package pwmcapture8_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam logic [7:0] SAT = 8'hff;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pwmcapture8_if.sv
// pwmcapture8 control and result bundle.
// master drives the input side, slave is the capture block.
interface pwmcapture8_if;

    logic       samplece;
    logic       pwmin;
    logic       invertpwm;
    logic [7:0] hightime;
    logic [7:0] period;
    logic       newsample;
    logic       overflow;
    logic       stale;

    modport master (
        output samplece, pwmin, invertpwm,
        input  hightime, period, newsample, overflow, stale
    );

    modport slave (
        input  samplece, pwmin, invertpwm,
        output hightime, period, newsample, overflow, stale
    );

endinterface

// File: rtl/pwmcapture8_inputfilter.sv
// Two-flop synchronizer plus tick-based glitch filter.
// A new level must persist FILTER_LEN ticks before it is accepted.
module pwmcapture8_inputfilter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic samplece,
    input  logic pwmin,
    output logic filtered
);

    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q, filt_d;
    logic [3:0] filtcnt_q, filtcnt_d;

    always_comb begin
        sync1_d   = pwmin;
        sync2_d   = sync1_q;
        filt_d    = filt_q;
        filtcnt_d = filtcnt_q;
        if (samplece) begin
            if (sync2_q != filt_q) begin
                if (filtcnt_q + 4'd1 == FILT_MAX) begin
                    filt_d    = ~filt_q;
                    filtcnt_d = '0;
                end else begin
                    filtcnt_d = filtcnt_q + 4'd1;
                end
            end else begin
                filtcnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            filt_q    <= 1'b0;
            filtcnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            filt_q    <= filt_d;
            filtcnt_q <= filtcnt_d;
        end
    end

    assign filtered = filt_q;

endmodule

// File: rtl/pwmcapture8.sv
// PWM capture: measures active-phase length and rise-to-rise period
// in sample ticks, with timeout-driven stale reporting.
module pwmcapture8
    import pwmcapture8_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic          clk,
    input logic          reset,
    pwmcapture8_if.slave bus
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    logic       filtered;
    logic       level;
    logic       rise, fall, is_edge, timeout;
    logic       level_q, level_d;
    state_e     state_q, state_d;
    logic [7:0] hicnt_q, hicnt_d;
    logic [7:0] percnt_q, percnt_d;
    logic [7:0] idlecnt_q, idlecnt_d;
    logic [7:0] hightime_q, hightime_d;
    logic [7:0] period_q, period_d;
    logic       newsample_q, newsample_d;
    logic       overflow_q, overflow_d;
    logic       stale_q, stale_d;

    pwmcapture8_inputfilter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .samplece(bus.samplece),
        .pwmin   (bus.pwmin),
        .filtered(filtered)
    );

    assign level   = filtered ^ bus.invertpwm;
    assign rise    = bus.samplece & level & ~level_q;
    assign fall    = bus.samplece & ~level & level_q;
    assign is_edge = rise | fall;
    // An edge on the timeout tick clears idlecnt and wins.
    assign timeout = bus.samplece & ~is_edge &
                     (idlecnt_q != TO_CNT) &
                     (idlecnt_q + 8'd1 == TO_CNT);

    always_comb begin
        level_d     = level_q;
        state_d     = state_q;
        hicnt_d     = hicnt_q;
        percnt_d    = percnt_q;
        idlecnt_d   = idlecnt_q;
        hightime_d  = hightime_q;
        period_d    = period_q;
        newsample_d = 1'b0;
        overflow_d  = overflow_q;
        stale_d     = stale_q;
        if (bus.samplece) begin
            level_d = level;
            if (is_edge) begin
                idlecnt_d = '0;
            end else if (idlecnt_q != TO_CNT) begin
                idlecnt_d = idlecnt_q + 8'd1;
            end
            unique case (state_q)
                ST_SYNC: begin
                    if (rise) begin
                        hicnt_d  = 8'd1;
                        percnt_d = 8'd1;
                        state_d  = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        percnt_d = sat_inc(percnt_q);
                        state_d  = ST_LOW;
                    end else begin
                        hicnt_d  = sat_inc(hicnt_q);
                        percnt_d = sat_inc(percnt_q);
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        hightime_d  = hicnt_q;
                        period_d    = percnt_q;
                        overflow_d  = (percnt_q == SAT);
                        newsample_d = 1'b1;
                        stale_d     = 1'b0;
                        hicnt_d     = 8'd1;
                        percnt_d    = 8'd1;
                        state_d     = ST_HIGH;
                    end else begin
                        percnt_d = sat_inc(percnt_q);
                    end
                end
                default: state_d = ST_SYNC;
            endcase
            if (timeout) begin
                stale_d    = 1'b1;
                hightime_d = level ? SAT : 8'd0;
                period_d   = 8'd0;
                overflow_d = 1'b0;
                state_d    = ST_SYNC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q     <= 1'b0;
            state_q     <= ST_SYNC;
            hicnt_q     <= '0;
            percnt_q    <= '0;
            idlecnt_q   <= '0;
            hightime_q  <= '0;
            period_q    <= '0;
            newsample_q <= 1'b0;
            overflow_q  <= 1'b0;
            stale_q     <= 1'b1;
        end else begin
            level_q     <= level_d;
            state_q     <= state_d;
            hicnt_q     <= hicnt_d;
            percnt_q    <= percnt_d;
            idlecnt_q   <= idlecnt_d;
            hightime_q  <= hightime_d;
            period_q    <= period_d;
            newsample_q <= newsample_d;
            overflow_q  <= overflow_d;
            stale_q     <= stale_d;
        end
    end

    assign bus.hightime  = hightime_q;
    assign bus.period    = period_q;
    assign bus.newsample = newsample_q;
    assign bus.overflow  = overflow_q;
    assign bus.stale     = stale_q;

endmodule

// File: tb/tb_pwmcapture8.sv
// Self-checking bench for pwmcapture8: directed and random waveforms
// scored against an edge-timestamp reference model.
module tb_pwmcapture8;

    localparam int F = 3;
    localparam int T = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pwmcapture8_if bus ();

    pwmcapture8 #(
        .FILTER_LEN(F),
        .TIMEOUT   (T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   raw[$];
    bit   inv;
    bit   quarter;
    int   g_ht[$], g_per[$], g_ov[$];
    int   m_ht[$], m_per[$], m_ov[$];
    int   e_ht, e_per, e_ov, e_st;
    logic ns_prev = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.newsample === 1'b1) begin
            check("ns_width", int'(ns_prev), 0);
            check("ns_stale", int'(bus.stale), 0);
            g_ht.push_back(int'(bus.hightime));
            g_per.push_back(int'(bus.period));
            g_ov.push_back(int'(bus.overflow));
        end
        ns_prev = bus.newsample;
    end

    task automatic add_seg(input int lv, input int len);
        for (int i = 0; i < len; i++) raw.push_back(lv);
    endtask

    // Reference: filtered level per tick, then rise/fall timestamps.
    // A rise publishes when the preceding rise and fall were reached
    // without any idle gap longer than T ticks.
    task automatic model();
        int arr[$];
        int lvl[$];
        int et[$], er[$];
        int filt, run, prev, lv, n;
        int pub_t, to_t, a, b;
        arr = {};
        if (!quarter) begin
            arr.push_back(0);
            arr.push_back(0);
        end
        foreach (raw[i]) arr.push_back(raw[i]);
        n = arr.size();
        filt = 0; run = 0; prev = 0;
        for (int k = 0; k < n; k++) begin
            lv = filt ^ int'(inv);
            lvl.push_back(lv);
            if (lv != prev) begin
                et.push_back(k);
                er.push_back(lv);
            end
            prev = lv;
            if (arr[k] != filt) begin
                run++;
                if (run == F) begin
                    filt = 1 - filt;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
        m_ht = {}; m_per = {}; m_ov = {};
        e_ht = 0; e_per = 0; e_ov = 0; e_st = 1;
        pub_t = -1;
        for (int i = 2; i < et.size(); i++) begin
            if (er[i] == 1 && er[i-1] == 0 && er[i-2] == 1 &&
                et[i-1] - et[i-2] <= T && et[i] - et[i-1] <= T) begin
                m_ht.push_back((et[i-1] - et[i-2] > 255) ? 255 : et[i-1] - et[i-2]);
                m_per.push_back((et[i] - et[i-2] > 255) ? 255 : et[i] - et[i-2]);
                m_ov.push_back((et[i] - et[i-2] >= 255) ? 1 : 0);
                pub_t = et[i];
            end
        end
        to_t = -1;
        a = -1;
        for (int i = 0; i <= et.size(); i++) begin
            b = (i < et.size()) ? et[i] : n;
            if (b - a > T) to_t = a + T;
            a = b;
        end
        if (pub_t > to_t && m_ht.size() > 0) begin
            e_ht  = m_ht[m_ht.size()-1];
            e_per = m_per[m_per.size()-1];
            e_ov  = m_ov[m_ov.size()-1];
            e_st  = 0;
        end else if (to_t >= 0) begin
            e_ht  = (lvl[to_t] == 1) ? 255 : 0;
            e_per = 0;
            e_ov  = 0;
            e_st  = 1;
        end
    endtask

    task automatic run_scn(input string nm);
        int len;
        len = raw.size();
        @(negedge clk);
        g_ht = {}; g_per = {}; g_ov = {};
        reset = 1'b1;
        bus.samplece = 1'b0;
        bus.invertpwm = inv;
        bus.pwmin = raw[0][0];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check({nm, "_rst_ht"}, int'(bus.hightime), 0);
        check({nm, "_rst_per"}, int'(bus.period), 0);
        check({nm, "_rst_ns"}, int'(bus.newsample), 0);
        check({nm, "_rst_ov"}, int'(bus.overflow), 0);
        check({nm, "_rst_st"}, int'(bus.stale), 1);
        if (!quarter) begin
            for (int j = 0; j < len + 2; j++) begin
                bus.samplece = 1'b1;
                bus.pwmin = raw[(j < len) ? j : len - 1][0];
                @(negedge clk);
            end
        end else begin
            for (int k = 0; k < len; k++) begin
                for (int c = 0; c < 4; c++) begin
                    bus.samplece = (c == 3);
                    bus.pwmin = raw[k][0];
                    @(negedge clk);
                end
            end
        end
        bus.samplece = 1'b0;
        repeat (2) @(negedge clk);
        model();
        check({nm, "_count"}, g_ht.size(), m_ht.size());
        for (int i = 0; i < g_ht.size() && i < m_ht.size(); i++) begin
            check({nm, "_ht"}, g_ht[i], m_ht[i]);
            check({nm, "_per"}, g_per[i], m_per[i]);
            check({nm, "_ov"}, g_ov[i], m_ov[i]);
        end
        check({nm, "_end_ht"}, int'(bus.hightime), e_ht);
        check({nm, "_end_per"}, int'(bus.period), e_per);
        check({nm, "_end_ov"}, int'(bus.overflow), e_ov);
        check({nm, "_end_st"}, int'(bus.stale), e_st);
    endtask

    task automatic last_pub(input string nm, input int ht, input int per, input int ov);
        if (g_ht.size() > 0) begin
            check({nm, "_k_ht"}, g_ht[g_ht.size()-1], ht);
            check({nm, "_k_per"}, g_per[g_per.size()-1], per);
            check({nm, "_k_ov"}, g_ov[g_ov.size()-1], ov);
        end
    endtask

    initial begin
        int lv, nseg, r, len;
        bus.samplece = 1'b0;
        bus.pwmin = 1'b0;
        bus.invertpwm = 1'b0;

        inv = 0; quarter = 0;
        raw = {}; add_seg(0, 4);
        repeat (4) begin add_seg(1, 3); add_seg(0, 5); end
        add_seg(1, 3); add_seg(0, 12);
        run_scn("basic");
        last_pub("basic", 3, 8, 0);

        raw = {}; add_seg(0, 4);
        repeat (5) begin add_seg(1, 101); add_seg(0, 155); end
        add_seg(1, 101); add_seg(0, 12);
        run_scn("loop");
        last_pub("loop", 101, 255, 1);

        raw = {}; add_seg(0, 4);
        repeat (2) begin add_seg(1, 5); add_seg(0, 10); end
        add_seg(1, 5); add_seg(0, 4); add_seg(1, 2); add_seg(0, 4);
        add_seg(1, 5); add_seg(0, 10); add_seg(1, 5); add_seg(0, 12);
        run_scn("glitch");
        last_pub("glitch", 5, 15, 0);

        raw = {}; add_seg(0, 4);
        repeat (2) begin add_seg(1, 3); add_seg(0, 5); end
        add_seg(1, 300);
        run_scn("to_hi");
        check("to_hi_st", int'(bus.stale), 1);
        check("to_hi_ht", int'(bus.hightime), 255);
        check("to_hi_per", int'(bus.period), 0);

        raw = {}; add_seg(0, 4);
        add_seg(1, 3); add_seg(0, 5); add_seg(1, 3); add_seg(0, 305);
        run_scn("to_lo");
        check("to_lo_st", int'(bus.stale), 1);
        check("to_lo_ht", int'(bus.hightime), 0);

        raw = {}; add_seg(0, 300);
        repeat (3) begin add_seg(1, 3); add_seg(0, 5); end
        add_seg(1, 3); add_seg(0, 12);
        run_scn("resume");
        check("resume_st", int'(bus.stale), 0);

        raw = {}; add_seg(0, 4);
        add_seg(1, 255); add_seg(0, 10);
        add_seg(1, 5); add_seg(0, 10); add_seg(1, 5); add_seg(0, 12);
        run_scn("edge255");
        if (g_ht.size() > 0) check("edge255_first_ht", g_ht[0], 255);

        raw = {}; add_seg(0, 4);
        add_seg(1, 256); add_seg(0, 10);
        add_seg(1, 5); add_seg(0, 10); add_seg(1, 5); add_seg(0, 12);
        run_scn("edge256");
        last_pub("edge256", 5, 15, 0);

        raw = {}; add_seg(0, 6); add_seg(1, 6);
        run_scn("rstmid_a");
        raw = {}; add_seg(1, 10); add_seg(0, 7); add_seg(1, 4);
        add_seg(0, 9); add_seg(1, 6); add_seg(0, 12);
        run_scn("rstmid_b");
        if (g_ht.size() > 0) check("rstmid_first_per", g_per[0], 17);

        inv = 1;
        for (int q = 0; q < 2; q++) begin
            quarter = q[0];
            raw = {}; add_seg(1, 6);
            repeat (4) begin add_seg(0, 3); add_seg(1, 5); end
            add_seg(0, 3); add_seg(1, 12);
            run_scn(q == 0 ? "inv" : "inv_q");
            last_pub(q == 0 ? "inv" : "inv_q", 3, 8, 0);
        end

        for (int s = 0; s < 6; s++) begin
            inv = $urandom_range(0, 1) == 1;
            quarter = $urandom_range(0, 1) == 1;
            raw = {};
            lv = int'($urandom_range(0, 1));
            nseg = int'($urandom_range(8, 14));
            for (int i = 0; i < nseg; i++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) len = int'($urandom_range(1, F - 1));
                else if (r == 1) len = int'($urandom_range(240, 270));
                else len = int'($urandom_range(F, 120));
                add_seg(lv, len);
                lv = 1 - lv;
            end
            add_seg(lv, 12);
            run_scn($sformatf("rand%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwmcapture8.md
# pwmcapture8

Measures an incoming single-ended PWM signal and reports its high time and period, both in sample ticks. It is the receive-side counterpart of the 8-bit PWM channel, for measuring command PWM from an external controller or looping back the channel's own output for self-test. The input is synchronized, glitch-filtered and optionally inverted before measurement. Results are published once per complete period with a one-cycle strobe. A stale flag and forced DC values report a missing or stuck input.

## Interface
- FILTER_LEN, 3: consecutive sample ticks that a new input level must persist before it is accepted (1..15).
- TIMEOUT, 255: sample ticks without an accepted edge before the input is declared stale (2..255).

- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- samplece  input  1  sample-tick clock enable; same role as the PWM channel's counter enable.
- pwmin  input  1  asynchronous PWM input.
- invertpwm  input  1  when 1, the low phase of pwmin is measured as the active phase.
- hightime  output  8  active-phase length of the last complete period, in ticks; saturates at 255.
- period  output  8  rise-to-rise length of the last complete period, in ticks; saturates at 255.
- newsample  output  1  one-clk strobe; hightime and period were updated this cycle.
- overflow  output  1  the published period counter saturated.
- stale  output  1  no valid measurement: set after reset or timeout, cleared by newsample.

## Operation
- **Synchronizer.** Two flip-flops on every clk, not gated by samplece.
- **Filter.**
  - Applies only on samplece ticks.
  - If the synchronized input differs from the filtered level, increment filtcnt; otherwise clear filtcnt.
  - When filtcnt reaches FILTER_LEN, toggle the filtered level and clear filtcnt.
- **Active level.** level = filtered XOR invertpwm. A rise or fall of level is an edge.
  - Toggling invertpwm creates an edge immediately, and it is processed like any other edge.
  - Firmware writes invertpwm only while stale=1.
- **FSM states** (SYNC, HIGH, LOW). All transitions happen on samplece cycles only.
  - SYNC: wait for a rising edge and discard partial periods. On rise, set hicnt=1, percnt=1, go to HIGH.
  - HIGH: each tick with no edge, increment hicnt and percnt, both saturating at 255. On fall, increment percnt and go to LOW.
  - LOW: each tick, increment percnt (saturating).
  - LOW, on rise:
    - Publish hightime<=hicnt, period<=percnt, overflow<=(percnt==255).
    - Pulse newsample and clear stale.
    - Reload hicnt=1, percnt=1 and go to HIGH.
- **Timeout.**
  - idlecnt counts ticks since the last edge and clears on every edge.
  - When idlecnt reaches TIMEOUT:
    - set stale=1;
    - set hightime=255 if level=1, otherwise 0;
    - set period=0 and overflow=0;
    - go to SYNC.
  - No newsample is issued on timeout.
  - idlecnt holds at TIMEOUT until the next edge.
- **Simultaneous events.** An edge on the same tick as the timeout wins: idlecnt clears and the timeout is suppressed.
- **Reset values.**
  - hightime=0, period=0, newsample=0, overflow=0, stale=1.
  - FSM in SYNC; synchronizer, filter, counters and filtered level all 0.
- **Reset mid-period.** The measurement in progress is discarded. The first result after reset needs one full period following the first rise.

## Timing
- pwmin change to synchronized: 2 clk.
- Synchronized change to accepted edge: FILTER_LEN samplece ticks. Shorter pulses are rejected.
- hightime, period, overflow and newsample are registered. They update in the clk cycle after the samplece cycle that accepted the rising edge.
- newsample is exactly one clk wide. There is at most one newsample per rising edge.
- With samplece held low, the FSM, filter and counters are frozen.
- Minimum measurable phase: FILTER_LEN ticks.

## Structure
- Shared constants file holds:
  - FSM state encodings (SYNC, HIGH, LOW);
  - the saturation value 8'hff.
- One sub-module, inputfilter: synchronizer plus glitch filter. Inputs: clk, reset, samplece, pwmin. Output: filtered.
- Edge detection, FSM, counters and timeout live in the top module pwmcapture8.

## Test plan
- Basic period: samplece every clk, FILTER_LEN=3, pwmin high 3 ticks then low 5 ticks, repeated → after the second rise, newsample pulses with hightime=3, period=8, stale=0, overflow=0.
- Loopback with the PWM channel:
  - shared samplece, PWM value 100, repeated → hightime=101, period=256-clamped to 255, overflow=1;
  - same setup with TIMEOUT irrelevant → values stable across 4 periods.
- Glitch rejection: a 2-tick high glitch inside the low phase, FILTER_LEN=3 → no edge; period unchanged at 8.
- Timeout:
  - pwmin held high for TIMEOUT+1 ticks → stale=1, hightime=255, period=0, no newsample;
  - held low instead → hightime=0;
  - normal PWM then resumes → stale clears at the second rise.
- Reset in HIGH state after 2 ticks → all outputs at reset values, stale=1; the first newsample comes only after a full subsequent period.
- Inversion: invertpwm=1 with pwmin low 3 ticks and high 5 ticks → hightime=3, period=8; samplece at 1/4 duty leaves the tick counts unchanged.
